bin2bcd_seq: RTL

Parametrised, iterative binary-to-BCD converter using shift-and-add-3 (double dabble), with valid/ready handshakes on both sides and an optional signed (sign-magnitude) mode. It replaces the fixed 8-bit, 3-digit pipelined lookup converter for wide operands, where a lookup table and adder tree would be too large. It sits between datapath counters or measurement results and display/UART formatting logic. It performs one shift per clock, so area scales linearly with digit count and latency scales with input width.

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_dabble_digit.sv | 23 ++
 rtl/bin2bcd_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared types, constants and helpers for the iterative
//                binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Bits per BCD digit
    localparam int BCD_DIGIT_W = 4;

    // Converter control states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Smallest digit count that can hold the largest magnitude of a
    // width-bit operand: 2^w - 1 when unsigned, 2^(w-1) when signed.
    function automatic int min_bcd_digits(input int width, input bit is_signed);
        longint unsigned v_max;
        int              n_dig;
        if (is_signed)
            v_max = 64'd1 << (width - 1);
        else
            v_max = (64'd1 << width) - 64'd1;
        n_dig = 1;
        while (v_max >= 64'd10) begin
            v_max = v_max / 64'd10;
            n_dig = n_dig + 1;
        end
        return n_dig;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_dabble_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dabble_digit
//  Description : Add-3 correction for one BCD digit ahead of a left shift,
//                so a digit of 5..9 carries correctly into the next digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Digits of 5 or more would become >= 10 when doubled; pre-add 3
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_DIGIT_W'(5))
            o_digit = i_digit + BCD_DIGIT_W'(3);
    end

endmodule : bcd_dabble_digit
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Iterative shift-and-add-3 binary-to-BCD converter with
//                valid/ready on both sides and optional sign-magnitude mode.
//                One operand bit is shifted per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
)
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          out_neg
);

    localparam int                 c_bcd_w    = BCD_DIGIT_W * DIGITS;
    localparam int                 c_cnt_w    = $clog2(BIN_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);
    localparam bit                 c_signed   = (SIGNED != 0);

    // Reject configurations whose digit count cannot hold the full range
    if (BIN_W < 2) begin : g_bad_width
        $error("bin2bcd_seq: BIN_W must be at least 2");
    end
    if (DIGITS < min_bcd_digits(BIN_W, c_signed)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for BIN_W/SIGNED");
    end

    state_e               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [BIN_W-1:0]     r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_neg;
    logic [c_bcd_w-1:0]   r_bcd_out;
    logic                 r_neg_out;

    logic                 w_load_neg;
    logic [BIN_W-1:0]     w_load_mag;
    logic [c_bcd_w-1:0]   w_bcd_adj;
    logic [c_bcd_w-1:0]   w_bcd_final;

    // Magnitude of the incoming operand; -2^(BIN_W-1) wraps to exactly
    // 2^(BIN_W-1) which is correct when read as unsigned.
    always_comb begin
        w_load_neg = c_signed && bin_in[BIN_W-1];
        w_load_mag = bin_in;
        if (w_load_neg)
            w_load_mag = (~bin_in) + BIN_W'(1);
    end

    // Per-digit add-3 correction applied to the accumulator before each shift
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_dabble_digit u_digit (
            .i_digit (r_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Accumulator contents after the final shift, captured into the output
    assign w_bcd_final = {w_bcd_adj[c_bcd_w-2:0], r_bin[BIN_W-1]};

    // Control FSM, shift datapath and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_neg     <= 1'b0;
            r_bcd_out <= '0;
            r_neg_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_bin   <= w_load_mag;
                        r_neg   <= w_load_neg;
                        r_bcd   <= '0;
                        r_cnt   <= c_cnt_load;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt - c_cnt_last;
                    if (r_cnt == c_cnt_last) begin
                        r_bcd_out <= w_bcd_final;
                        r_neg_out <= r_neg;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags decode the state register only
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign bcd_out   = r_bcd_out;
    assign out_neg   = r_neg_out;

endmodule : bin2bcd_seq
`default_nettype wire
